// File: rtl/sample_uart_tx.sv
// Serialises each 16-bit ADC sample as a 3-byte 8N1 UART frame:
// sync byte, sample[15:8], sample[7:0].
// A one-entry holding buffer absorbs one sample that arrives while a frame is
// in flight. Any further arrivals are dropped and counted.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line idle (tx=1), waiting for a strobe or buffered word
// S_START | start bit (tx=0) of byte r_byte_idx
// S_DATA  | data bit r_bit_idx of byte r_byte_idx, LSB first
// S_STOP  | stop bit (tx=1); frame ends after byte 2
module sample_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic        clkouta,
   input  logic        rst_n,
   input  logic [15:0] sample_data,
   input  logic        sample_vld,
   output logic        tx,
   output logic        busy,
   output logic        frame_done,
   output logic        drop_pulse,
   output logic [7:0]  drop_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   localparam logic [15:0] LP_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      r_state, w_state_nxt;
   logic [15:0] r_baud, w_baud_nxt;
   logic [2:0]  r_bit_idx, w_bit_nxt;
   logic [1:0]  r_byte_idx, w_byte_nxt;
   logic [15:0] r_word, w_word_nxt;
   logic        r_hold_full, w_hold_full_nxt;
   logic [15:0] r_hold_data, w_hold_data_nxt;
   logic        r_tx, w_tx_nxt;
   logic        r_drop_pulse, w_drop;
   logic [7:0]  r_drop_cnt;
   logic        w_bit_end, w_frame_end;
   logic        w_load_hold, w_load_direct;
   logic [7:0]  w_cur_byte;

   assign w_bit_end   = (r_baud == LP_BAUD_LAST);
   assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_byte_idx == 2'd2);

   // FSM state register with the bit/byte sequencing counters and the word in flight
   always_ff @(posedge clkouta) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_byte_idx <= '0;
         r_word     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud     <= w_baud_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_byte_idx <= w_byte_nxt;
         r_word     <= w_word_nxt;
      end
   end

   // Next-state logic. A new frame starts from IDLE or straight out of the
   // final stop bit, and the buffered word takes priority over a fresh strobe.
   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud + 16'd1;
      w_bit_nxt     = r_bit_idx;
      w_byte_nxt    = r_byte_idx;
      w_word_nxt    = r_word;
      w_load_hold   = 1'b0;
      w_load_direct = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_baud_nxt = '0;
            if (r_hold_full)     w_load_hold   = 1'b1;
            else if (sample_vld) w_load_direct = 1'b1;
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_nxt = S_DATA;
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_baud_nxt = '0;
               if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
               else                   w_bit_nxt   = r_bit_idx + 3'd1;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_baud_nxt = '0;
               if (r_byte_idx != 2'd2) begin
                  w_state_nxt = S_START;
                  w_byte_nxt  = r_byte_idx + 2'd1;
               end else if (r_hold_full) begin
                  w_load_hold = 1'b1;
               end else if (sample_vld) begin
                  w_load_direct = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_load_hold || w_load_direct) begin
         w_state_nxt = S_START;
         w_baud_nxt  = '0;
         w_byte_nxt  = '0;
         w_word_nxt  = w_load_hold ? r_hold_data : sample_data;
      end
   end

   // Holding buffer. While it is being unloaded it counts as empty, so a
   // strobe in that cycle is stored rather than dropped.
   always_comb begin
      w_hold_full_nxt = r_hold_full;
      w_hold_data_nxt = r_hold_data;
      w_drop          = 1'b0;
      if (w_load_hold) w_hold_full_nxt = 1'b0;
      if (sample_vld && !w_load_direct) begin
         if (!r_hold_full || w_load_hold) begin
            w_hold_full_nxt = 1'b1;
            w_hold_data_nxt = sample_data;
         end else begin
            w_drop = 1'b1;
         end
      end
   end

   // Output decode. tx is computed from the next state so the registered
   // line shows the start bit on the cycle right after the strobe.
   always_comb begin
      case (w_byte_nxt)
         2'd1:    w_cur_byte = w_word_nxt[15:8];
         2'd2:    w_cur_byte = w_word_nxt[7:0];
         default: w_cur_byte = SYNC_BYTE;
      endcase
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_cur_byte[w_bit_nxt];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   // Registered line driver, holding buffer and drop accounting (count saturates at 255)
   always_ff @(posedge clkouta) begin
      if (!rst_n) begin
         r_tx         <= 1'b1;
         r_hold_full  <= 1'b0;
         r_hold_data  <= '0;
         r_drop_pulse <= 1'b0;
         r_drop_cnt   <= '0;
      end else begin
         r_tx         <= w_tx_nxt;
         r_hold_full  <= w_hold_full_nxt;
         r_hold_data  <= w_hold_data_nxt;
         r_drop_pulse <= w_drop;
         if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign tx         = r_tx;
   assign busy       = (r_state != S_IDLE);
   assign frame_done = w_frame_end;
   assign drop_pulse = r_drop_pulse;
   assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_sample_uart_tx.sv
// Bench for sample_uart_tx. The stimulus side steps a frame-timeline model and
// queues the frame it expects next. A monitor on the falling edge decodes the
// tx line cycle by cycle against that queue.
module tb_sample_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 30 * CPB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] sample_data = '0;
   logic        sample_vld = 1'b0;
   logic        tx, busy, frame_done, drop_pulse;
   logic [7:0]  drop_cnt;

   sample_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
      .clkouta    (clk),
      .rst_n      (rst_n),
      .sample_data(sample_data),
      .sample_vld (sample_vld),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done),
      .drop_pulse (drop_pulse),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] w;
      int          start;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   // reference model: end cycle of the current frame, one holding slot, drop count
   int          m_end = 0;
   logic        m_hold = 1'b0;
   logic [15:0] m_hold_w = '0;
   int          m_drops = 0;

   // monitor state
   logic        in_frame = 1'b0;
   int          fidx = 0;
   int          ferr = 0;
   exp_t        cur;
   int          obs_pulses = 0;
   int          idle_errs = 0;
   int          frames_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // value the line must carry at offset i (0..FRAME-1) into a frame of word w
   function automatic logic bitval(input logic [15:0] w, input int i);
      int         k, j;
      logic [7:0] b;
      k = i / (10 * CPB);
      j = (i % (10 * CPB)) / CPB;
      b = (k == 0) ? 8'hA5 : (k == 1) ? w[15:8] : w[7:0];
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return b[j-1];
   endfunction

   function automatic void model_reset();
      m_end   = 0;
      m_hold  = 1'b0;
      m_drops = 0;
      q.delete();
   endfunction

   // one cycle c of the timeline: a frame started by a strobe in cycle c
   // occupies c+1 .. c+FRAME; a buffered word goes out right after m_end
   function automatic void model_step(input int c, input logic vld, input logic [15:0] d);
      exp_t e;
      if (m_hold && c == m_end) begin
         e.w = m_hold_w; e.start = m_end + 1;
         q.push_back(e);
         m_end  = m_end + FRAME;
         m_hold = 1'b0;
      end
      if (vld) begin
         if (c >= m_end) begin
            e.w = d; e.start = c + 1;
            q.push_back(e);
            m_end = c + FRAME;
         end else if (!m_hold) begin
            m_hold   = 1'b1;
            m_hold_w = d;
         end else begin
            m_drops++;
         end
      end
   endfunction

   task automatic step(input logic vld, input logic [15:0] d);
      @(posedge clk); #1;
      sample_vld  = vld;
      sample_data = d;
      model_step(cyc, vld, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rst_n      = 1'b0;
         sample_vld = 1'b0;
         model_reset();
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_step(cyc, 1'b0, 16'h0);
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         if (q.size() == 0 && !in_frame && !m_hold && cyc > m_end + 2) break;
         step(1'b0, 16'h0);
      end
      chk("drain_done", (q.size() == 0 && !in_frame) ? 32'd1 : 32'd0, 32'd1);
   endtask

   // monitor: decode every cycle of each frame; outside frames the line must be quiet
   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame   = 1'b0;
         obs_pulses = 0;
      end else begin
         if (drop_pulse === 1'b1) obs_pulses++;
         if (!in_frame && tx === 1'b0) begin
            in_frame = 1'b1;
            fidx     = 0;
            ferr     = 0;
            chk("frame_expected", (q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (q.size() != 0) begin
               cur = q.pop_front();
               chk("frame_start_cycle", cyc, cur.start);
            end else begin
               cur.w = 16'h0; cur.start = cyc;
            end
         end
         if (in_frame) begin
            if (tx !== bitval(cur.w, fidx)) ferr++;
            if (busy !== 1'b1) ferr++;
            if (frame_done !== (fidx == FRAME - 1)) ferr++;
            fidx++;
            if (fidx == FRAME) begin
               in_frame = 1'b0;
               frames_seen++;
               chk($sformatf("frame_bits_%04h", cur.w), ferr, 0);
            end
         end else begin
            if (busy !== 1'b0 || frame_done !== 1'b0 || tx !== 1'b1 || drop_cnt === 8'hxx)
               idle_errs++;
         end
      end
   end

   initial begin
      int tx_bad;
      int sat;

      do_reset(3);
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_drop_pulse", drop_pulse, 0);

      tx_bad = 0;
      for (int i = 0; i < 200; i++) begin
         step(1'b0, 16'h0);
         @(negedge clk);
         if (tx !== 1'b1) tx_bad++;
      end
      chk("idle_tx_high_200", tx_bad, 0);

      // single frame
      step(1'b1, 16'h1234);
      step(1'b0, 16'h0);
      @(negedge clk);
      chk("start_bit_latency", {busy, tx}, 2'b10);
      drain();

      // buffered back-to-back
      step(1'b1, 16'hBEEF);
      idle(9);
      step(1'b1, 16'hCAFE);
      drain();
      chk("btb_drop_cnt", drop_cnt, 0);

      // overflow
      step(1'b1, 16'h0001);
      idle(9);
      step(1'b1, 16'h0002);
      idle(9);
      step(1'b1, 16'h0003);
      drain();
      chk("ovf_drop_cnt", drop_cnt, 1);
      chk("ovf_drop_pulses", obs_pulses, 1);

      // random strobes with random gaps (gap 0 gives consecutive strobes)
      for (int i = 0; i < 60; i++) begin
         step(1'b1, 16'($urandom));
         idle($urandom_range(0, 160));
      end
      drain();
      chk("rand_drop_pulses", obs_pulses, m_drops);
      chk("rand_drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);

      // saturation: a strobe every cycle for long enough to force over 300 drops
      do_reset(2);
      for (int i = 0; i < 310; i++) step(1'b1, 16'($urandom));
      drain();
      sat = obs_pulses;
      chk("sat_drop_cnt", drop_cnt, 255);
      chk("sat_drop_pulses", sat, m_drops);
      chk("sat_over_300", (sat >= 300) ? 32'd1 : 32'd0, 32'd1);

      // reset in the middle of the second byte, with the holding buffer full
      step(1'b1, 16'h5A5A);
      idle(9);
      step(1'b1, 16'h1111);
      idle(40);
      @(posedge clk); #1;
      rst_n = 1'b0; sample_vld = 1'b0; model_reset();
      @(posedge clk); #1;
      model_reset();
      @(negedge clk);
      chk("midrst_tx", tx, 1);
      chk("midrst_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_step(cyc, 1'b0, 16'h0);
      idle(5);
      step(1'b1, 16'h00FF);
      drain();
      chk("midrst_drop_cnt", drop_cnt, 0);

      chk("queue_empty", q.size(), 0);
      chk("idle_line_quiet", idle_errs, 0);
      chk("frames_seen_min", (frames_seen >= 8) ? 32'd1 : 32'd0, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sample_uart_tx.md
Name: sample_uart_tx

Overview:
Serialising consumer for the ADC board-interface sample port. It takes each 16-bit captured sample with its valid strobe and transmits it as a 3-byte UART frame on a single tx line: sync byte 0xA5, then sample[15:8], then sample[7:0]. It runs in the ADC output clock domain, alongside the capture logic, and feeds the host UART link. A one-entry holding buffer absorbs a sample that arrives mid-frame; any further arrival while busy is dropped and counted.

Parameters:
CLKS_PER_BIT, 434, clkouta cycles per UART bit; legal range 2..65535.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clkouta  in  1  ADC output clock; all logic on rising edge.
rst_n  in  1  synchronous reset, active-low.
sample_data  in  16  sample word; sampled only in a cycle where sample_vld=1.
sample_vld  in  1  one-cycle strobe: sample_data is valid this cycle.
tx  out  1  UART line, 8N1, LSB first, idle high; registered.
busy  out  1  high from the first start-bit cycle through the last stop-bit cycle of a frame.
frame_done  out  1  one-cycle pulse in the final cycle of the last stop bit of each frame.
drop_pulse  out  1  one-cycle pulse when an incoming sample is discarded.
drop_cnt  out  8  saturating count of discarded samples; saturates at 255.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - tx=1, busy=0, frame_done=0, drop_pulse=0, drop_cnt=0.
  - Holding buffer cleared; FSM returns to IDLE.
  - A frame in progress is aborted immediately; tx returns high in the next cycle.
- FSM states: IDLE, START, DATA, STOP.
  - Byte index byte_idx ranges 0..2; bit index bit_idx ranges 0..7.
  - Baud counter runs 0..CLKS_PER_BIT-1; each bit holds tx for exactly CLKS_PER_BIT cycles.
- IDLE:
  - If sample_vld=1, capture sample_data into the shift word, set byte_idx=0, go to START.
  - The start bit (tx=0) and busy=1 appear on the cycle after the strobe (1-cycle latency).
  - Otherwise, if the holding buffer is full, load it, clear it, and go to START the same way.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA:
  - tx carries bit bit_idx of the current byte.
  - Current byte: byte_idx 0 = SYNC_BYTE, 1 = word[15:8], 2 = word[7:0].
  - After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - At the end of STOP, if byte_idx<2: increment byte_idx and go to START. No idle gap between bytes.
  - At the end of STOP, if byte_idx==2: pulse frame_done.
    - If the holding buffer is full, load it and go straight to START. busy stays 1; the next cycle is a start bit.
    - Otherwise go to IDLE; busy=0 on the next cycle.
- Frame length: exactly 30*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- sample_vld while busy (or in the cycle the FSM leaves IDLE):
  - Holding buffer empty: store sample_data; no drop.
  - Holding buffer full: discard the new sample and keep the older one; pulse drop_pulse; drop_cnt += 1 unless it is already 255.
- sample_vld in the same cycle the holding buffer is being unloaded: the buffer counts as empty, so the new sample is stored.
- sample_vld in the frame_done cycle with an empty buffer: the new sample is stored and starts the next frame immediately.
- The word being transmitted is never modified mid-frame by new samples.

Test Plan:
- Use CLKS_PER_BIT=4 throughout.
- Reset: hold rst_n=0 for 3 cycles -> tx=1, busy=0, drop_cnt=0. With no strobes, tx stays 1 for 200 cycles.
- Single frame: one strobe with sample_data=16'h1234 -> start bit begins 1 cycle later. tx decodes to bytes A5, 12, 34, each as 0, 8 data bits LSB first, 1, with 4 cycles per bit. busy is high for exactly 120 cycles; frame_done fires once, in cycle 120.
- Buffered back-to-back: strobe 16'hBEEF, then strobe 16'hCAFE 10 cycles later -> frames A5 BE EF then A5 CA FE. The second start bit immediately follows the first frame's last stop bit; busy stays high for 240 cycles; drop_cnt=0.
- Overflow: strobes of 16'h0001, 0002, 0003 at 10-cycle spacing -> frames for 0001 and 0002 are sent. 0003 is dropped: one drop_pulse, drop_cnt=1.
- Saturation: 300 drops forced in overlap -> drop_cnt stops at 255 and drop_pulse still pulses on every drop.
- Reset mid-frame: rst_n=0 during the second data byte -> tx=1 on the next cycle, busy=0, buffer empty. After release, a strobe of 16'h00FF yields a clean frame A5 00 FF.
